// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end owning the PC, driving a 1-cycle imem and feeding decode over valid/ready.
//    clock/reset              single clock, synchronous active-high reset
//    imem_addr/imem_q         imem address out, read data for the previous cycle's address in
//    insn_valid/insn_ready    decode handshake; insn_out/pc_out are zero when not valid
//    redirect_en/redirect_pc  squash fetched work and restart at redirect_pc
//    halt                     stop issuing; already-fetched words still deliver
//    fetch_count              accepted transfers, wrapping at 2^32
module fetch_stage #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_q,
   output logic                  insn_valid,
   input  logic                  insn_ready,
   output logic [DATA_WIDTH-1:0] insn_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   input  logic                  redirect_en,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  halt,
   output logic [31:0]           fetch_count
);
   typedef enum logic {STREAM, HOLD} state_t;
   state_t st, st_n;
   logic [ADDR_WIDTH-1:0] fpc, inflight_pc, hold_pc;
   logic [DATA_WIDTH-1:0] hold_insn;
   logic inflight, issue, capture, transfer;
   // an undelivered word is parked in the hold regs, because imem_q only lives for one cycle
   assign capture = st == STREAM & inflight & !insn_ready & !redirect_en;
   assign issue = !reset & !halt & !redirect_en & (st == STREAM ? (insn_ready | !inflight) : insn_ready);
   assign transfer = insn_valid & insn_ready;
   always_ff @(posedge clock) begin
      if (reset) begin
         st <= STREAM;
         fpc <= RESET_PC;
         inflight <= 1'b0;
         inflight_pc <= '0;
         hold_insn <= '0;
         hold_pc <= '0;
         fetch_count <= '0;
      end else begin
         st <= st_n;
         fpc <= redirect_en ? redirect_pc : issue ? fpc + 1'b1 : fpc;
         inflight <= issue;
         inflight_pc <= issue ? fpc : inflight_pc;
         hold_insn <= redirect_en ? '0 : capture ? imem_q : hold_insn;
         hold_pc <= redirect_en ? '0 : capture ? inflight_pc : hold_pc;
         fetch_count <= transfer ? fetch_count + 32'd1 : fetch_count;
      end
   end
   always_comb st_n = redirect_en ? STREAM : capture ? HOLD : (st == HOLD & insn_ready) ? STREAM : st;
   always_comb begin
      insn_valid = !reset & !redirect_en & (st == HOLD | inflight);
      insn_out = !insn_valid ? '0 : st == HOLD ? hold_insn : imem_q;
      pc_out = !insn_valid ? '0 : st == HOLD ? hold_pc : inflight_pc;
      imem_addr = reset ? RESET_PC : redirect_en ? redirect_pc : fpc;
   end
endmodule
